// File: rtl/cale_de_date_div_pkg.sv
// cale_de_date_div_pkg -- shared definitions for the restoring divider.
//   WIDTH_DEF      : default operand/result width
//   PHASES_PER_BIT : clock cycles spent per quotient bit (SHIFT, SUB, COMMIT)
//   state_t        : divider FSM states
//   cnt_width()    : bit counter width for a given operand width
package cale_de_date_div_pkg;

  localparam int WIDTH_DEF      = 8;
  localparam int PHASES_PER_BIT = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    SUB    = 3'd2,
    COMMIT = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Counter must index WIDTH bits; never collapse to a zero-width vector.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/cale_de_date_div_scazator.sv
// scazator_div -- combinational WIDTH+1-bit trial subtractor.
//   i_a      : partial remainder
//   i_b      : divisor
//   o_diff   : low WIDTH bits of i_a - i_b
//   o_borrow : 1 when i_b > i_a
module scazator_div
  import cale_de_date_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow
);

  logic [WIDTH:0] w_full;

  // Zero-extend both operands so the extra MSB carries the borrow.
  assign w_full   = {1'b0, i_a} - {1'b0, i_b};
  assign o_diff   = w_full[WIDTH-1:0];
  assign o_borrow = w_full[WIDTH];

endmodule

// File: rtl/cale_de_date_div.sv
// cale_de_date_div -- multi-cycle unsigned restoring divider driven by an
// external controller.
//   clk, reset           : clock, synchronous active-high reset
//   reset_data           : clears the datapath, forces IDLE
//   load                 : captures dividend/divisor (IDLE or DONE only)
//   busy                 : enables the SHIFT/SUB/COMMIT phases
//   readyCtrl            : rising edge in DONE publishes the result
//   dividend, divisor    : unsigned operands
//   quotient, remainder  : published result
//   div_by_zero          : published result had a zero divisor
//   ready                : one-cycle pulse the cycle after publication
//   overrun              : sticky, readyCtrl rose before DONE
module cale_de_date_div
  import cale_de_date_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reset_data,
  input  logic             load,
  input  logic             busy,
  input  logic             readyCtrl,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             ready,
  output logic             overrun
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH:0]   r_trial;
  logic [CW-1:0]    r_cnt;
  logic             r_loaded;
  logic             r_dbz;
  // Bit shifted out of R on SHIFT: when set the shifted remainder is
  // >= 2^WIDTH > D, so the subtraction succeeds regardless of the borrow.
  logic             r_carry;
  logic             r_rc_d;
  logic             r_pub;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz_out;
  logic             r_ready;
  logic             r_overrun;

  logic [WIDTH-1:0] w_diff;
  logic             w_borrow;
  logic             w_rc_rise;
  logic             w_can_load;

  scazator_div #(.WIDTH(WIDTH)) u_sub (
    .i_a      (r_r),
    .i_b      (r_d),
    .o_diff   (w_diff),
    .o_borrow (w_borrow)
  );

  assign w_rc_rise  = readyCtrl & ~r_rc_d;
  assign w_can_load = (r_state == IDLE) || (r_state == DONE);

  // FSM and datapath: reset > reset_data > load > phase step.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_q      <= '0;
      r_r      <= '0;
      r_d      <= '0;
      r_trial  <= '0;
      r_cnt    <= '0;
      r_loaded <= 1'b0;
      r_dbz    <= 1'b0;
      r_carry  <= 1'b0;
    end else if (reset_data) begin
      r_state  <= IDLE;
      r_q      <= '0;
      r_r      <= '0;
      r_d      <= '0;
      r_cnt    <= '0;
      r_loaded <= 1'b0;
      r_carry  <= 1'b0;
    end else if (load && w_can_load) begin
      r_state  <= IDLE;
      r_q      <= dividend;
      r_d      <= divisor;
      r_r      <= '0;
      r_cnt    <= '0;
      r_loaded <= 1'b1;
      r_dbz    <= (divisor == '0);
      r_carry  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (busy && r_loaded) begin
            r_state <= SHIFT;
          end else begin
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          if (busy) begin
            {r_carry, r_r, r_q} <= {r_r, r_q, 1'b0};
            r_state             <= SUB;
          end
        end
        SUB: begin
          if (busy) begin
            r_trial <= {w_borrow, w_diff};
            r_state <= COMMIT;
          end
        end
        COMMIT: begin
          if (busy) begin
            if (!r_trial[WIDTH] || r_carry) begin
              r_r    <= r_trial[WIDTH-1:0];
              r_q[0] <= 1'b1;
            end
            r_carry <= 1'b0;
            r_cnt   <= r_cnt + CW'(1);
            if (r_cnt == CNT_LAST) begin
              r_state <= DONE;
            end else begin
              r_state <= SHIFT;
            end
          end
        end
        DONE: begin
          r_state <= DONE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Result publication, ready pulse and overrun flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rc_d    <= 1'b0;
      r_pub     <= 1'b0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_dbz_out <= 1'b0;
      r_ready   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_rc_d  <= readyCtrl;
      r_ready <= r_pub;
      if (w_rc_rise && (r_state == DONE)) begin
        r_quot    <= r_q;
        r_rem     <= r_r;
        r_dbz_out <= r_dbz;
        r_pub     <= 1'b1;
      end else begin
        r_pub <= 1'b0;
      end
      if (reset_data) begin
        r_overrun <= 1'b0;
      end else if (w_rc_rise && (r_state != DONE)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz_out;
  assign ready       = r_ready;
  assign overrun     = r_overrun;

endmodule
